// File: rtl/ws2812_pkg.sv
// Shared types and default widths for the WS2812 mode router slice.
package ws2812_pkg;

   // Router sequencing: normal operation, wait for frame end, switch point, blank frame in flight
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SWITCH = 2'd2,
      ST_BLANK  = 2'd3
   } router_state_e;

   localparam int KEY_W_DEF  = 5;
   localparam int NUM_W_DEF  = 6;
   localparam int DATA_W_DEF = 24;

endpackage

// File: rtl/ws2812_frame_tracker.sv
// Frame bookkeeping for the shared ws2812_ctrl: in-frame flag, one-deep pending
// start, per-frame watchdog and the registered start pulse to the controller.
module ws2812_frame_tracker #(
   parameter int FRAME_TMO = 2000000
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic start_req,    // start request from the active engine
   input  logic start_force,  // unconditional start (blank frame)
   input  logic hold,         // block engine starts and drop any pending one
   input  logic frame_done,
   output logic in_frame,
   output logic start_pulse,
   output logic frame_end,
   output logic tmo_hit
);

   localparam int CNT_W = (FRAME_TMO > 1) ? $clog2(FRAME_TMO) : 1;

   logic [CNT_W-1:0] cnt;
   logic             pend;
   logic             issue;

   // Frame end is a real frame_done or watchdog expiry; a start may go out the
   // same cycle a frame ends so a queued request is never lost.
   always_comb begin
      tmo_hit   = (FRAME_TMO != 0) && in_frame && (cnt == CNT_W'(FRAME_TMO - 1));
      frame_end = in_frame && (frame_done || tmo_hit);
      issue     = start_force ||
                  (!hold && (start_req || pend) && (!in_frame || frame_end));
   end

   // Frame flag, pending start, watchdog count and registered start pulse
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         in_frame    <= 1'b0;
         pend        <= 1'b0;
         start_pulse <= 1'b0;
         cnt         <= '0;
      end else begin
         start_pulse <= issue;
         if (issue)
            in_frame <= 1'b1;
         else if (frame_end)
            in_frame <= 1'b0;
         if (hold || issue)
            pend <= 1'b0;
         else if (start_req && in_frame)
            pend <= 1'b1;
         if (issue || frame_end || !in_frame)
            cnt <= '0;
         else
            cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/ws2812_mode_router.sv
// Routes keys and frame requests between NUM_MODES display engines and the
// shared ws2812_ctrl. Mode changes happen only between frames, optionally with
// one all-zero frame sent in between.
module ws2812_mode_router #(
   parameter int NUM_MODES   = 4,
   parameter int MODE_W      = 2,
   parameter int KEY_W       = ws2812_pkg::KEY_W_DEF,
   parameter int NUM_W       = ws2812_pkg::NUM_W_DEF,
   parameter int DATA_W      = ws2812_pkg::DATA_W_DEF,
   parameter bit BLANK_ON_SW = 1'b1,
   parameter int FRAME_TMO   = 2000000
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst_n,
   input  logic [MODE_W-1:0]             mode_req,
   input  logic [KEY_W-1:0]              key_in,
   input  logic [NUM_MODES-1:0]          eng_start,
   input  logic [NUM_MODES*NUM_W-1:0]    eng_num,
   input  logic [NUM_MODES*DATA_W-1:0]   eng_data,
   output logic [NUM_MODES*KEY_W-1:0]    key_out,
   input  logic                          cfg_start,
   input  logic                          frame_done,
   output logic                          ws2812_start,
   output logic [NUM_W-1:0]              cfg_num,
   output logic [DATA_W-1:0]             cfg_data,
   output logic [MODE_W-1:0]             mode_act,
   output logic                          sw_pulse,
   output logic                          tmo_err
);
   import ws2812_pkg::*;

   router_state_e               state;
   logic [MODE_W-1:0]           target;
   logic                        act_start;
   logic [NUM_W-1:0]            act_num;
   logic [DATA_W-1:0]           act_data;
   logic                        req_ok;
   logic                        mode_chg;
   logic                        run_open;
   logic                        start_force;
   logic [NUM_MODES*KEY_W-1:0]  key_nxt;
   logic                        in_frame;
   logic                        frame_end;
   logic                        tmo_hit;

   // cfg_start goes straight to the engines outside this block
   logic unused_cfg_start;
   assign unused_cfg_start = cfg_start;

   // Select the active engine's start/num/data slice
   always_comb begin
      act_start = 1'b0;
      act_num   = '0;
      act_data  = '0;
      for (int i = 0; i < NUM_MODES; i++) begin
         if (mode_act == MODE_W'(i)) begin
            act_start = eng_start[i];
            act_num   = eng_num[i*NUM_W +: NUM_W];
            act_data  = eng_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Mode-change detect; RUN is "open" to keys/starts only when not being left
   always_comb begin
      req_ok      = int'(mode_req) < NUM_MODES;
      mode_chg    = (state == ST_RUN) && req_ok && (mode_req != mode_act);
      run_open    = (state == ST_RUN) && !mode_chg;
      start_force = (state == ST_SWITCH) && BLANK_ON_SW;
      cfg_num     = act_num;
      cfg_data    = (state == ST_BLANK) ? '0 : act_data;
   end

   // Key demux: only the active slice can carry a key, and only while open
   always_comb begin
      key_nxt = '0;
      for (int i = 0; i < NUM_MODES; i++) begin
         if (run_open && (mode_act == MODE_W'(i)))
            key_nxt[i*KEY_W +: KEY_W] = key_in;
      end
   end

   ws2812_frame_tracker #(
      .FRAME_TMO (FRAME_TMO)
   ) u_tracker (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .start_req   (act_start),
      .start_force (start_force),
      .hold        (!run_open),
      .frame_done  (frame_done),
      .in_frame    (in_frame),
      .start_pulse (ws2812_start),
      .frame_end   (frame_end),
      .tmo_hit     (tmo_hit)
   );

   // Router FSM with registered keys, switch pulse and sticky watchdog flag
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= ST_RUN;
         mode_act <= '0;
         target   <= '0;
         sw_pulse <= 1'b0;
         key_out  <= '0;
         tmo_err  <= 1'b0;
      end else begin
         sw_pulse <= 1'b0;
         key_out  <= key_nxt;
         if (tmo_hit)
            tmo_err <= 1'b1;
         case (state)
            ST_RUN: begin
               if (mode_chg) begin
                  target <= mode_req;
                  // a frame ending this very cycle needs no drain
                  state  <= (in_frame && !frame_end) ? ST_DRAIN : ST_SWITCH;
               end
            end
            ST_DRAIN: begin
               if (frame_end)
                  state <= ST_SWITCH;
            end
            ST_SWITCH: begin
               if (BLANK_ON_SW) begin
                  state <= ST_BLANK;
               end else begin
                  mode_act <= target;
                  sw_pulse <= 1'b1;
                  state    <= ST_RUN;
               end
            end
            ST_BLANK: begin
               if (frame_end) begin
                  mode_act <= target;
                  sw_pulse <= 1'b1;
                  state    <= ST_RUN;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_mode_router.sv
// Bench for ws2812_mode_router: directed scenarios plus a randomized run
// against a frame/mode reference model. Second instance covers direct switch
// and disabled watchdog.
module tb_ws2812_mode_router;

   localparam int NM  = 4;
   localparam int KW  = 5;
   localparam int NW  = 6;
   localparam int DW  = 24;
   localparam int TMO = 100;

   logic               sys_clk   = 1'b0;
   logic               sys_rst_n = 1'b1;
   logic [2:0]         mode_req;
   logic [1:0]         mode_req_d;
   logic [KW-1:0]      key_in;
   logic [NM-1:0]      eng_start;
   logic [NM*NW-1:0]   eng_num;
   logic [NM*DW-1:0]   eng_data;
   logic               cfg_start, frame_done;

   logic [NM*KW-1:0]   key_out, key_out_d;
   logic               ws_start, ws_start_d;
   logic [NW-1:0]      cfg_num, cfg_num_d;
   logic [DW-1:0]      cfg_data, cfg_data_d;
   logic [2:0]         mode_act;
   logic [1:0]         mode_act_d;
   logic               sw_pulse, sw_pulse_d, tmo_err, tmo_err_d;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 sys_clk = ~sys_clk;

   ws2812_mode_router #(.NUM_MODES(NM), .MODE_W(3), .KEY_W(KW), .NUM_W(NW), .DATA_W(DW),
                        .BLANK_ON_SW(1'b1), .FRAME_TMO(TMO)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mode_req(mode_req), .key_in(key_in),
      .eng_start(eng_start), .eng_num(eng_num), .eng_data(eng_data), .key_out(key_out),
      .cfg_start(cfg_start), .frame_done(frame_done), .ws2812_start(ws_start),
      .cfg_num(cfg_num), .cfg_data(cfg_data), .mode_act(mode_act), .sw_pulse(sw_pulse),
      .tmo_err(tmo_err));

   ws2812_mode_router #(.NUM_MODES(NM), .MODE_W(2), .KEY_W(KW), .NUM_W(NW), .DATA_W(DW),
                        .BLANK_ON_SW(1'b0), .FRAME_TMO(0)) dutd (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mode_req(mode_req_d), .key_in(key_in),
      .eng_start(eng_start), .eng_num(eng_num), .eng_data(eng_data), .key_out(key_out_d),
      .cfg_start(cfg_start), .frame_done(frame_done), .ws2812_start(ws_start_d),
      .cfg_num(cfg_num_d), .cfg_data(cfg_data_d), .mode_act(mode_act_d), .sw_pulse(sw_pulse_d),
      .tmo_err(tmo_err_d));

   // reference model state
   int             m_mode, m_target, m_phase, m_age;
   bit             m_in, m_pend, m_tmo, m_start, m_sw;
   logic [NM*KW-1:0] m_keys;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic clear_inputs();
      mode_req   = '0;
      mode_req_d = '0;
      key_in     = '0;
      eng_start  = '0;
      eng_num    = '0;
      eng_data   = '0;
      cfg_start  = 1'b0;
      frame_done = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      sys_rst_n = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
   endtask

   task automatic model_reset();
      m_mode = 0; m_target = 0; m_phase = 0; m_age = 0;
      m_in = 0; m_pend = 0; m_tmo = 0; m_start = 0; m_sw = 0;
      m_keys = '0;
   endtask

   // One clock of the router as described: frames, pending start, mode sequence
   task automatic model_step();
      bit over, chg;
      int req;
      req  = int'(mode_req);
      over = m_in && (frame_done || m_age == TMO - 1);
      if (m_in && m_age == TMO - 1) m_tmo = 1;
      chg = (m_phase == 0) && (req < NM) && (req != m_mode);
      m_start = 0; m_sw = 0; m_keys = '0;
      case (m_phase)
         0: if (chg) begin
               m_target = req;
               m_pend   = 0;
               m_phase  = (m_in && !over) ? 1 : 2;
            end else begin
               m_keys[m_mode*KW +: KW] = key_in;
               if ((eng_start[m_mode] || m_pend) && (!m_in || over)) begin
                  m_start = 1; m_pend = 0;
               end else if (eng_start[m_mode] && m_in) begin
                  m_pend = 1;
               end
            end
         1: if (over) m_phase = 2;
         2: begin m_start = 1; m_phase = 3; end
         default: if (over) begin m_mode = m_target; m_sw = 1; m_phase = 0; end
      endcase
      if (m_start) begin m_in = 1; m_age = 0; end
      else if (over) begin m_in = 0; m_age = 0; end
      else if (m_in) m_age++;
   endtask

   task automatic test_reset();
      clear_inputs();
      #2 sys_rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({ws_start, key_out, cfg_num, cfg_data, mode_act, sw_pulse, tmo_err} !== '0) begin
         n_bad++; $display("FAIL reset_outputs: got %0h required 0",
                           {ws_start, key_out, cfg_num, cfg_data, mode_act, sw_pulse, tmo_err});
      end
      n_cmp++;
      if ({ws_start_d, key_out_d, cfg_num_d, cfg_data_d, mode_act_d, sw_pulse_d, tmo_err_d} !== '0) begin
         n_bad++; $display("FAIL reset_outputs_d: got %0h required 0",
                           {ws_start_d, key_out_d, cfg_num_d, cfg_data_d, mode_act_d, sw_pulse_d, tmo_err_d});
      end
      repeat (2) @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
   endtask

   task automatic test_keys();
      do_reset();
      key_in = 5'b00100;
      tick();
      key_in = '0;
      n_cmp++;
      if (key_out !== 20'h00004) begin n_bad++; $display("FAIL key_route: got %h required 00004", key_out); end
      tick();
      n_cmp++;
      if (key_out !== '0) begin n_bad++; $display("FAIL key_clear: got %h required 0", key_out); end
   endtask

   task automatic test_start();
      do_reset();
      eng_start = 4'b0010; tick(); eng_start = '0;
      n_cmp++;
      if (ws_start !== 1'b0) begin n_bad++; $display("FAIL inactive_start: got %b required 0", ws_start); end
      eng_start = 4'b0001; tick(); eng_start = '0;
      n_cmp++;
      if (ws_start !== 1'b1) begin n_bad++; $display("FAIL idle_start: got %b required 1", ws_start); end
      tick();
      eng_start = 4'b0001; tick(); eng_start = '0;
      tick();
      eng_start = 4'b0001; tick(); eng_start = '0;
      n_cmp++;
      if (ws_start !== 1'b0) begin n_bad++; $display("FAIL midframe_start: got %b required 0", ws_start); end
      frame_done = 1'b1; tick(); frame_done = 1'b0;
      n_cmp++;
      if (ws_start !== 1'b1) begin n_bad++; $display("FAIL pend_start: got %b required 1", ws_start); end
      tick();
      n_cmp++;
      if (ws_start !== 1'b0) begin n_bad++; $display("FAIL pend_collapse: got %b required 0", ws_start); end
      frame_done = 1'b1; eng_start = 4'b0001; tick(); frame_done = 1'b0; eng_start = '0;
      n_cmp++;
      if (ws_start !== 1'b1) begin n_bad++; $display("FAIL done_plus_start: got %b required 1", ws_start); end
      frame_done = 1'b1; tick(); frame_done = 1'b0;
   endtask

   task automatic test_switch();
      do_reset();
      eng_start = 4'b0001; tick(); eng_start = '0;
      mode_req = 3'd1; key_in = 5'b11111; tick(); key_in = '0;
      n_cmp++;
      if (key_out !== '0) begin n_bad++; $display("FAIL key_drop_leave: got %h required 0", key_out); end
      key_in = 5'b00001; eng_start = 4'b0011; tick(); key_in = '0; eng_start = '0;
      n_cmp++;
      if ({key_out, ws_start} !== '0) begin n_bad++; $display("FAIL drain_block: got %h required 0", {key_out, ws_start}); end
      tick();
      frame_done = 1'b1; tick(); frame_done = 1'b0;
      n_cmp++;
      if (ws_start !== 1'b0 || mode_act !== 3'd0) begin
         n_bad++; $display("FAIL drain_end: got start %b mode %0d required 0 0", ws_start, mode_act);
      end
      tick();
      n_cmp++;
      if (ws_start !== 1'b1) begin n_bad++; $display("FAIL blank_start: got %b required 1", ws_start); end
      for (int i = 0; i < 3; i++) begin
         eng_data  = {$urandom(), $urandom(), $urandom()} | 96'h000001_000001_000001_000001;
         eng_num   = 24'($urandom());
         cfg_start = 1'b1;
         #1;
         n_cmp++;
         if (cfg_data !== '0 || cfg_num !== eng_num[NW-1:0]) begin
            n_bad++; $display("FAIL blank_data: got data %h num %h required 0 %h", cfg_data, cfg_num, eng_num[NW-1:0]);
         end
         tick();
         cfg_start = 1'b0;
      end
      frame_done = 1'b1; tick(); frame_done = 1'b0;
      n_cmp++;
      if (mode_act !== 3'd1 || sw_pulse !== 1'b1) begin
         n_bad++; $display("FAIL commit: got mode %0d pulse %b required 1 1", mode_act, sw_pulse);
      end
      tick();
      n_cmp++;
      if (sw_pulse !== 1'b0 || cfg_data !== eng_data[2*DW-1:DW]) begin
         n_bad++; $display("FAIL after_commit: got pulse %b data %h required 0 %h", sw_pulse, cfg_data, eng_data[2*DW-1:DW]);
      end
   endtask

   task automatic test_direct_switch();
      do_reset();
      mode_req_d = 2'd2;
      tick();
      n_cmp++;
      if (mode_act_d !== 2'd0 || ws_start_d !== 1'b0) begin
         n_bad++; $display("FAIL direct_sw1: got mode %0d start %b required 0 0", mode_act_d, ws_start_d);
      end
      tick();
      n_cmp++;
      if (mode_act_d !== 2'd2 || sw_pulse_d !== 1'b1 || ws_start_d !== 1'b0) begin
         n_bad++; $display("FAIL direct_sw2: got mode %0d pulse %b start %b required 2 1 0", mode_act_d, sw_pulse_d, ws_start_d);
      end
      tick();
      n_cmp++;
      if (sw_pulse_d !== 1'b0) begin n_bad++; $display("FAIL direct_sw3: got pulse %b required 0", sw_pulse_d); end
   endtask

   task automatic test_watchdog();
      int early;
      early = 0;
      do_reset();
      eng_start = 4'b0001; tick(); eng_start = '0;
      for (int i = 1; i < TMO; i++) begin
         tick();
         if (tmo_err !== 1'b0) early++;
      end
      n_cmp++;
      if (early != 0) begin n_bad++; $display("FAIL tmo_early: got %0d early cycles required 0", early); end
      tick();
      n_cmp++;
      if (tmo_err !== 1'b1) begin n_bad++; $display("FAIL tmo_fire: got %b required 1", tmo_err); end
      eng_start = 4'b0001; tick(); eng_start = '0;
      n_cmp++;
      if (ws_start !== 1'b1) begin n_bad++; $display("FAIL tmo_restart: got %b required 1", ws_start); end
      n_cmp++;
      if (tmo_err_d !== 1'b0) begin n_bad++; $display("FAIL tmo_disabled: got %b required 0", tmo_err_d); end
   endtask

   task automatic test_invalid_and_reset();
      // continues from the watchdog scenario: tmo_err set, a frame in flight
      frame_done = 1'b1; tick(); frame_done = 1'b0;
      mode_req = 3'd5; key_in = 5'b01000; tick(); key_in = '0;
      n_cmp++;
      if (key_out !== 20'h00008) begin n_bad++; $display("FAIL invalid_keys: got %h required 00008", key_out); end
      tick(); tick();
      n_cmp++;
      if (mode_act !== 3'd0 || sw_pulse !== 1'b0 || tmo_err !== 1'b1) begin
         n_bad++; $display("FAIL invalid_mode: got mode %0d pulse %b tmo %b required 0 0 1", mode_act, sw_pulse, tmo_err);
      end
      mode_req = 3'd2; tick(); tick();
      frame_done = 1'b1; tick(); frame_done = 1'b0;
      n_cmp++;
      if (mode_act !== 3'd2) begin n_bad++; $display("FAIL to_mode2: got %0d required 2", mode_act); end
      eng_data = {$urandom(), $urandom(), $urandom()} | 96'h000001_000001_000001_000001;
      mode_req = 3'd3; tick(); tick();
      n_cmp++;
      if (ws_start !== 1'b1 || cfg_data !== '0) begin
         n_bad++; $display("FAIL blank_2to3: got start %b data %h required 1 0", ws_start, cfg_data);
      end
      #2 sys_rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({ws_start, mode_act, sw_pulse, tmo_err, key_out} !== '0 || cfg_data !== eng_data[DW-1:0]) begin
         n_bad++; $display("FAIL async_reset: got start %b mode %0d tmo %b data %h required 0 0 0 %h",
                           ws_start, mode_act, tmo_err, cfg_data, eng_data[DW-1:0]);
      end
      mode_req = 3'd0;
      #3 sys_rst_n = 1'b1;
      begin
         int seen;
         seen = 0;
         repeat (4) begin tick(); if (ws_start !== 1'b0) seen++; end
         n_cmp++;
         if (seen != 0) begin n_bad++; $display("FAIL post_reset_start: got %0d starts required 0", seen); end
      end
   endtask

   task automatic test_random();
      logic [NW-1:0] e_num;
      logic [DW-1:0] e_data;
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         key_in     = KW'($urandom());
         eng_start  = ($urandom_range(0, 3) == 0) ? NM'($urandom()) : '0;
         eng_num    = 24'($urandom());
         eng_data   = {$urandom(), $urandom(), $urandom()};
         cfg_start  = 1'($urandom());
         frame_done = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 39) == 0) mode_req = 3'($urandom_range(0, 7));
         model_step();
         tick();
         e_num  = eng_num[m_mode*NW +: NW];
         e_data = (m_phase == 3) ? '0 : eng_data[m_mode*DW +: DW];
         n_cmp++;
         if (ws_start !== m_start) begin n_bad++; $display("FAIL rnd_start c%0d: got %b required %b", c, ws_start, m_start); end
         n_cmp++;
         if (key_out !== m_keys) begin n_bad++; $display("FAIL rnd_keys c%0d: got %h required %h", c, key_out, m_keys); end
         n_cmp++;
         if (int'(mode_act) != m_mode || sw_pulse !== m_sw) begin
            n_bad++; $display("FAIL rnd_mode c%0d: got %0d/%b required %0d/%b", c, mode_act, sw_pulse, m_mode, m_sw);
         end
         n_cmp++;
         if (tmo_err !== m_tmo) begin n_bad++; $display("FAIL rnd_tmo c%0d: got %b required %b", c, tmo_err, m_tmo); end
         n_cmp++;
         if (cfg_num !== e_num || cfg_data !== e_data) begin
            n_bad++; $display("FAIL rnd_cfg c%0d: got %h/%h required %h/%h", c, cfg_num, cfg_data, e_num, e_data);
         end
      end
   endtask

   initial begin
      test_reset();
      test_direct_switch();
      test_keys();
      test_start();
      test_switch();
      test_watchdog();
      test_invalid_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
